// File: rtl/mult_seq_pkg.sv
// Shared types, widths and the term-selection helper for the multiply sequencer.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mseq_state_e;

  localparam int MSEQ_A_W = 16;
  localparam int MSEQ_C_W = 32;

  // Keeps the lowest one or two set bits of b; b & -b isolates the lowest.
  function automatic logic [MSEQ_A_W-1:0] low_two_bits_mask(input logic [MSEQ_A_W-1:0] b);
    logic [MSEQ_A_W-1:0] first;
    logic [MSEQ_A_W-1:0] rest;
    first = b & -b;
    rest  = b & ~first;
    return first | (rest & -rest);
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Operand and result handshakes of the multiply sequencer.
interface mult_sequencer_if #(parameter int N = 16);
  import mult_seq_pkg::*;

  localparam int IW = $clog2(N/2 + 1);

  logic                in_vld;
  logic                in_rdy;
  logic [MSEQ_A_W-1:0] in_a;
  logic [N-1:0]        in_b;
  logic                out_vld;
  logic                out_rdy;
  logic [MSEQ_C_W-1:0] out_c;
  logic [IW-1:0]       out_iters;

  modport master (
    output in_vld, in_a, in_b, out_rdy,
    input  in_rdy, out_vld, out_c, out_iters
  );

  modport slave (
    input  in_vld, in_a, in_b, out_rdy,
    output in_rdy, out_vld, out_c, out_iters
  );

endinterface

// File: rtl/two_bit_multiplier.sv
// Combinational partial-product datapath: a times a multiplier with at most two set bits,
// realised as the sum of two shifted copies of a.
module two_bit_multiplier
  import mult_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                vld,
  input  logic [MSEQ_A_W-1:0] a,
  input  logic [N-1:0]        b,
  output logic [MSEQ_C_W-1:0] c,
  output logic                result_vld
);

  localparam int IDX_W = $clog2(N);

  logic [N-1:0]       first;
  logic [N-1:0]       second;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   second_idx;
  logic [MSEQ_C_W-1:0] term0;
  logic [MSEQ_C_W-1:0] term1;

  assign first  = b & -b;
  assign second = b & ~first;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    first_idx  = '0;
    second_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (first[i])  first_idx  = IDX_W'(i);
      if (second[i]) second_idx = IDX_W'(i);
    end
  end

  assign term0      = (vld && |first)  ? (MSEQ_C_W'(a) << first_idx)  : '0;
  assign term1      = (vld && |second) ? (MSEQ_C_W'(a) << second_idx) : '0;
  assign c          = term0 + term1;
  assign result_vld = vld;

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle multiply controller: issues the multiplier two set bits per cycle to the
// two_bit_multiplier datapath and accumulates the exact 32-bit product.
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  mult_sequencer_if.slave  bus
);

  localparam int IW = $clog2(N/2 + 1);

  mseq_state_e         state;
  logic [MSEQ_A_W-1:0] a_reg;
  logic [N-1:0]        rem;
  logic [MSEQ_C_W-1:0] acc;
  logic [IW-1:0]       iters;
  logic                out_vld;
  logic [MSEQ_C_W-1:0] out_c;
  logic [IW-1:0]       out_iters;

  logic [MSEQ_A_W-1:0] mask_full;
  logic [N-1:0]        m;
  logic                dp_vld;
  logic [MSEQ_C_W-1:0] dp_c;
  logic                dp_result_vld_unused;

  assign mask_full = low_two_bits_mask(MSEQ_A_W'(rem));
  assign m         = mask_full[N-1:0];
  assign dp_vld    = (state == RUN);

  two_bit_multiplier #(.N(N)) u_dp (
    .vld        (dp_vld),
    .a          (a_reg),
    .b          (m),
    .c          (dp_c),
    .result_vld (dp_result_vld_unused)
  );

  // Gated with rst so the producer never sees ready while reset is asserted.
  assign bus.in_rdy    = (state == IDLE) && !rst;
  assign bus.out_vld   = out_vld;
  assign bus.out_c     = out_c;
  assign bus.out_iters = out_iters;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      rem       <= '0;
      acc       <= '0;
      iters     <= '0;
      out_vld   <= 1'b0;
      out_c     <= '0;
      out_iters <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_vld) begin
            a_reg <= bus.in_a;
            rem   <= bus.in_b;
            acc   <= '0;
            iters <= '0;
            if (bus.in_b == '0) begin
              state     <= DONE;
              out_vld   <= 1'b1;
              out_c     <= '0;
              out_iters <= '0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= acc + dp_c;
          rem   <= rem & ~m;
          iters <= iters + IW'(1);
          if ((rem & ~m) == '0) begin
            state     <= DONE;
            out_vld   <= 1'b1;
            out_c     <= acc + dp_c;
            out_iters <= iters + IW'(1);
          end
        end
        DONE: begin
          if (bus.out_rdy) begin
            state   <= IDLE;
            out_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corner cases plus random operands
// compared against a plain-arithmetic product/popcount model.
module tb_mult_sequencer;

  localparam int N  = 16;
  localparam int IW = $clog2(N/2 + 1);

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mult_sequencer_if #(.N(N)) bus ();

  mult_sequencer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcount(input logic [N-1:0] b);
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n += int'(b[i]);
    return n;
  endfunction

  // One full transaction: accept, latency, result, optional consumer stall, return to IDLE.
  task automatic do_op(input logic [15:0] a, input logic [N-1:0] b, input int stall);
    longint unsigned exp_c;
    int exp_iters;
    int exp_lat;
    int n;
    logic [31:0] held_c;

    exp_c     = longint'(a) * longint'(b);
    exp_iters = (popcount(b) + 1) / 2;
    exp_lat   = exp_iters + 1;

    n = 0;
    while (!bus.in_rdy && n < 50) begin
      tick();
      n++;
    end
    check("in_rdy_wait", 64'(bus.in_rdy), 64'd1);

    bus.in_vld  = 1'b1;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.out_rdy = (stall == 0);
    tick();
    bus.in_vld = 1'b0;

    n = 1;
    while (!bus.out_vld && n < 40) begin
      if (bus.in_rdy) check("busy_rdy", 64'(bus.in_rdy), 64'd0);
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("out_c", 64'(bus.out_c), exp_c);
    check("out_iters", 64'(bus.out_iters), 64'(exp_iters));
    held_c = bus.out_c;

    for (int s = 0; s < stall; s++) begin
      bus.in_vld = 1'($urandom_range(0, 1));
      bus.in_a   = 16'($urandom);
      bus.in_b   = N'($urandom);
      tick();
      check("stall_vld", 64'(bus.out_vld), 64'd1);
      check("stall_c", 64'(bus.out_c), 64'(held_c));
      check("stall_rdy", 64'(bus.in_rdy), 64'd0);
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    tick();
    check("post_vld", 64'(bus.out_vld), 64'd0);
    check("post_rdy", 64'(bus.in_rdy), 64'd1);
  endtask

  initial begin
    int quiet;
    logic [N-1:0] rb;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.out_rdy = 1'b1;

    tick();
    tick();
    check("rst_out_vld", 64'(bus.out_vld), 64'd0);
    check("rst_out_c", 64'(bus.out_c), 64'd0);
    check("rst_out_iters", 64'(bus.out_iters), 64'd0);
    check("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 64'(bus.in_rdy), 64'd1);

    do_op(16'd3, 16'h0000, 0);
    do_op(16'h00FF, 16'h0005, 0);
    do_op(16'd10, 16'h0007, 0);
    do_op(16'hFFFF, 16'hFFFF, 0);
    do_op(16'd7, 16'h8001, 5);

    // Reset in the third RUN cycle of the longest operation.
    bus.in_vld = 1'b1;
    bus.in_a   = 16'hFFFF;
    bus.in_b   = 16'hFFFF;
    tick();
    bus.in_vld = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_vld", 64'(bus.out_vld), 64'd0);
    check("mid_rst_rdy", 64'(bus.in_rdy), 64'd1);
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_vld) quiet++;
    end
    check("no_stale_result", 64'(quiet), 64'd0);
    do_op(16'd2, 16'h0003, 0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: rb = N'($urandom);
        1: rb = N'($urandom) & N'($urandom) & N'($urandom);
        2: rb = N'(1) << $urandom_range(0, N - 1);
        default: rb = N'($urandom) | N'($urandom);
      endcase
      do_op(16'($urandom), rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle multiply controller that drives the `two_bit_multiplier` datapath.
- Accepts a 16-bit multiplicand and an N-bit multiplier over a valid/ready handshake.
- Decomposes the multiplier into partial terms of at most two set bits each and issues one term per cycle to the datapath.
- Accumulates the partial products into an exact 32-bit result, returned over a second valid/ready handshake.
- Sits between an operand producer and a result consumer; only the multiply path uses it.

## Interface
Parameters:
- `N`, 16: multiplier width. Legal range 2..16, so the product always fits in 32 bits.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `in_vld`  in  1  — operand pair valid.
- `in_rdy`  out  1  — sequencer can accept a new operand pair.
- `in_a`  in  16  — multiplicand.
- `in_b`  in  N  — multiplier.
- `out_vld`  out  1  — result valid.
- `out_rdy`  in  1  — consumer accepts the result.
- `out_c`  out  32  — product `in_a*in_b`, unsigned, exact.
- `out_iters`  out  $clog2(N/2+1)  — number of datapath issue cycles used, equal to ceil(popcount(b)/2).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_rdy` = 1.
  - On `in_vld && in_rdy`, capture a_reg=`in_a` and rem=`in_b`; clear acc and iters.
  - Next state is RUN if `in_b` != 0, otherwise DONE.
- RUN, every cycle:
  - m = the lowest two set bits of rem (a single bit if rem has only one set bit).
  - Drive the datapath with vld=1, a=a_reg, b=m.
  - acc += datapath c; rem &= ~m; iters += 1.
  - If (rem & ~m) == 0, next state is DONE; otherwise stay in RUN.
- Datapath connection: the datapath is combinational.
  - Its `vld` is tied low outside RUN.
  - Its `result_vld` is not used for sequencing.
- DONE:
  - `out_vld` = 1; `out_c` = acc; `out_iters` = iters. All three held stable until `out_rdy`.
  - On `out_vld && out_rdy`, go to IDLE.
- Backpressure and busy behaviour:
  - `in_rdy` = 0 in RUN and DONE.
  - `in_vld` is ignored while busy; no queuing, no drop flag.
- Arithmetic:
  - acc is 32 bits. Each partial product is < 2^32 and the sum equals the exact product, so overflow cannot occur.
  - All values unsigned.
- Reset, including mid-RUN or mid-DONE: next state is IDLE.
  - acc, rem, a_reg, iters cleared.
  - `out_vld` = 0; any in-flight result is discarded.

## Timing
- Reset values: `out_vld`=0, `out_c`=0, `out_iters`=0.
- `in_rdy`:
  - 0 while `rst` is high.
  - 1 in the first cycle after `rst` deasserts.
- Latency, with the operand accepted on edge T0:
  - RUN occupies cycles T1..Tk, where k = ceil(popcount(b)/2).
  - `out_vld` rises in cycle Tk+1.
  - For b=0, `out_vld` rises in cycle T1.
- Throughput:
  - The earliest next accept is the cycle after the result handshake, since IDLE lasts at least one cycle.
  - Maximum occupancy is N/2 + 2 cycles per operation at full `out_rdy`.
- `out_c` and `out_iters`:
  - Registered; driven from acc and iters.
  - Valid only while `out_vld`=1; hold their value otherwise.
- Simultaneous `in_vld` during DONE together with `out_rdy`: not accepted that cycle (`in_rdy`=0); accepted next cycle in IDLE.

## Structure
- Package `mult_seq_pkg`:
  - state enum typedef `mseq_state_e` {IDLE, RUN, DONE};
  - constants `MSEQ_A_W`=16 and `MSEQ_C_W`=32;
  - function `low_two_bits_mask(b)`, returning the mask of the lowest ≤2 set bits.
- One sub-module instance: `two_bit_multiplier` #(.N(N)), as the partial-product datapath.
- Everything else (FSM, rem, acc, iters) lives in `mult_sequencer`.

## Test plan
- After reset:
  - all outputs 0 while `rst`=1;
  - `in_rdy`=1 on the next cycle.
- a=3, b=0:
  - `out_vld` in T1;
  - `out_c`=0, `out_iters`=0.
- a=16'h00FF, b=16'h0005:
  - one RUN cycle;
  - `out_c`=32'h000004FB, `out_iters`=1.
- a=10, b=16'h0007:
  - two RUN cycles;
  - `out_c`=70, `out_iters`=2.
- a=16'hFFFF, b=16'hFFFF:
  - eight RUN cycles;
  - `out_c`=32'hFFFE0001, `out_iters`=8.
- a=7, b=16'h8001, with `out_rdy` held low for 5 cycles:
  - `out_c`=32'h00038007 stays stable;
  - `in_rdy`=0; `in_vld` pulses are ignored;
  - after `out_rdy`, IDLE is reached in the next cycle.
- Reset during RUN:
  - stimulus: `rst` pulsed in the 3rd RUN cycle of the FFFF×FFFF case;
  - response: next cycle IDLE, `out_vld`=0, no result emitted;
  - follow-up op a=2, b=3 returns `out_c`=6.
